// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: execute-stage iterative multiply/divide unit.
// Owns the HI/LO registers. Runs MULT/MULTU/DIV/DIVU one radix-2 step per cycle and
// serves MFHI/MFLO/MTHI/MTLO. Stall_Ex freezes the front of the pipeline while busy.
// Optional build macro: MULDIV_EARLY_TERM_EN lets a multiply finish once the remaining
// multiplier bits are all zero.
module ex_muldiv_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  ALU_Op_Ex,
  input  logic [5:0]  Funct_Ex,
  input  logic [31:0] DataOne_Ex,
  input  logic [31:0] DataTwo_Ex,
  input  logic        Flush_Ex,
  output logic        Stall_Ex,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] Result_Ex
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(ITER - 1);

  localparam logic [5:0] FnMfhi = 6'h10;
  localparam logic [5:0] FnMthi = 6'h11;
  localparam logic [5:0] FnMflo = 6'h12;
  localparam logic [5:0] FnMtlo = 6'h13;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0]   r_b;       // mult: multiplicand; div: divisor
  logic          r_is_div;
  logic          r_neg_q;   // negate product / quotient
  logic          r_neg_r;   // negate remainder (dividend sign)

  logic        w_rtype, w_is_md, w_start, w_op_div, w_op_signed;
  logic        w_sign_a, w_sign_b, w_div0, w_last;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_mul_sum, w_div_diff;
  logic [63:0] w_mul_next, w_div_next, w_step, w_final, w_prod;
  logic [31:0] w_quo, w_rem, w_hi_res, w_lo_res;

  // Decode of the instruction currently held in ID/EX.
  always_comb begin
    w_rtype     = (ALU_Op_Ex == 2'b10);
    w_is_md     = w_rtype && (Funct_Ex[5:2] == 4'b0110);
    w_start     = (r_state == StIdle) && w_is_md && !Flush_Ex;
    w_op_div    = Funct_Ex[1];
    w_op_signed = !Funct_Ex[0];
    w_sign_a    = w_op_signed && DataOne_Ex[31];
    w_sign_b    = w_op_signed && DataTwo_Ex[31];
    w_abs_a     = w_sign_a ? (32'd0 - DataOne_Ex) : DataOne_Ex;
    w_abs_b     = w_sign_b ? (32'd0 - DataTwo_Ex) : DataTwo_Ex;
    w_div0      = (DataTwo_Ex == 32'd0);
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    w_mul_next = {w_mul_sum, r_acc[31:1]};
    w_div_diff = r_acc[63:31] - {1'b0, r_b};
    w_div_next = w_div_diff[32] ? {r_acc[62:0], 1'b0}
                                : {w_div_diff[31:0], r_acc[30:0], 1'b1};
    w_step     = r_is_div ? w_div_next : w_mul_next;
  end

`ifdef MULDIV_EARLY_TERM_EN
  logic [31:0]   r_mpr;     // multiplier bits not yet consumed
  logic [31:0]   w_mpr_next;
  logic [CW-1:0] w_shamt;

  // Finish early once no multiplier bits remain; align the product by the skipped steps.
  always_comb begin
    w_mpr_next = r_mpr >> 1;
    w_shamt    = LastCnt - r_cnt;
    w_last     = (r_cnt == LastCnt) || (!r_is_div && (w_mpr_next == 32'd0));
    w_final    = w_last ? (w_step >> w_shamt) : w_step;
  end

  // Track the remaining multiplier bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mpr <= 32'd0;
    end else if (w_start) begin
      r_mpr <= w_abs_b;
    end else if (r_state == StRun) begin
      r_mpr <= w_mpr_next;
    end
  end
`else
  // Fixed-length operation.
  always_comb begin
    w_last  = (r_cnt == LastCnt);
    w_final = w_step;
  end
`endif

  // Sign fix-up of the final step into HI/LO values.
  always_comb begin
    w_prod   = r_neg_q ? (64'd0 - w_final) : w_final;
    w_quo    = r_neg_q ? (32'd0 - w_final[31:0]) : w_final[31:0];
    w_rem    = r_neg_r ? (32'd0 - w_final[63:32]) : w_final[63:32];
    w_hi_res = r_is_div ? w_rem : w_prod[63:32];
    w_lo_res = r_is_div ? w_quo : w_prod[31:0];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and control outputs; flush wins over stall.
  always_comb begin
    w_state_next = r_state;
    Stall_Ex     = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    case (r_state)
      StIdle: begin
        Stall_Ex = w_start;
        if (w_start) w_state_next = StRun;
      end
      StRun: begin
        Busy     = 1'b1;
        Stall_Ex = !Flush_Ex;
        if (Flush_Ex)    w_state_next = StIdle;
        else if (w_last) w_state_next = StDone;
      end
      StDone: begin
        Done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand latch at issue, then one step per RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= 64'd0;
      r_b      <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_acc    <= {32'd0, w_op_div ? w_abs_a : w_abs_b};
      r_b      <= w_op_div ? w_abs_b : w_abs_a;
      r_is_div <= w_op_div;
      // Divide by zero keeps the all-ones quotient unsigned; the remainder fix-up
      // then restores the raw dividend.
      r_neg_q  <= (w_sign_a ^ w_sign_b) && !(w_op_div && w_div0);
      r_neg_r  <= w_sign_a;
    end else if (r_state == StRun) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_step;
    end
  end

  // HI/LO: written by the last RUN step or by MTHI/MTLO.
  always_ff @(posedge clock) begin
    if (reset) begin
      Hi <= 32'd0;
      Lo <= 32'd0;
    end else if ((r_state == StRun) && !Flush_Ex && w_last) begin
      Hi <= w_hi_res;
      Lo <= w_lo_res;
    end else if ((r_state == StIdle) && w_rtype && !Flush_Ex) begin
      if (Funct_Ex == FnMthi) Hi <= DataOne_Ex;
      if (Funct_Ex == FnMtlo) Lo <= DataOne_Ex;
    end
  end

  // MFHI/MFLO read path.
  always_comb begin
    Result_Ex = 32'd0;
    if (w_rtype && (Funct_Ex == FnMfhi)) Result_Ex = Hi;
    if (w_rtype && (Funct_Ex == FnMflo)) Result_Ex = Lo;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Execute-stage iterative multiply/divide unit. Sits directly downstream of the ID/EX pipeline register and consumes its decoded operands, ALU_Op and Funct fields. It runs MULT/MULTU/DIV/DIVU over multiple cycles, owns the architectural HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. While an operation is in progress it drives Stall_Ex to the hazard unit, which freezes PC, IF/ID and ID/EX.

Parameters:
ITER, 32, iterations per multiply/divide (one bit per cycle); counter width is clog2(ITER).

Ports:
clock  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
ALU_Op_Ex  in  2  ID/EX ALU_Op; 2'b10 = R-type, in which case Funct_Ex is decoded
Funct_Ex  in  6  function field: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO
DataOne_Ex  in  32  rs operand (multiplicand/dividend; MTHI/MTLO source)
DataTwo_Ex  in  32  rt operand (multiplier/divisor)
Flush_Ex  in  1  kill the current EX instruction; aborts any operation in progress
Stall_Ex  out  1  freeze request to the hazard unit
Busy  out  1  high in RUN
Done  out  1  one-cycle pulse when HI/LO are updated by a mult/div
Hi  out  32  HI register
Lo  out  32  LO register
Result_Ex  out  32  MFHI -> Hi, MFLO -> Lo, otherwise 0; combinational

Behaviour:
- Reset: synchronous, active-high. State=IDLE; Hi=Lo=0; Stall_Ex=Busy=Done=0; counter and datapath registers cleared. Reset during RUN or DONE aborts the operation and leaves no partial HI/LO write.
- start = (state==IDLE) & ALU_Op_Ex==2'b10 & Funct_Ex in {0x18..0x1B} & !Flush_Ex.
- States:
  - IDLE: Stall_Ex=start (combinational). On start, latch |DataOne_Ex|, |DataTwo_Ex| (signed ops) or the raw values (unsigned ops), latch the result sign bits and the op type, clear the counter, then go to RUN.
  - RUN: Stall_Ex=1, Busy=1. One radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide. After ITER steps (counter==ITER-1), write Hi/Lo, then go to DONE.
  - DONE: Stall_Ex=0, Done=1 for exactly one cycle. The mult/div instruction held in ID/EX advances. start is ignored in DONE, so the same instruction is never re-issued. Next state is IDLE.
- Latency: Stall_Ex high for ITER+1 cycles (issue cycle plus ITER RUN cycles). Hi/Lo are visible the cycle DONE is entered.
- Multiply: 64-bit product; Hi=product[63:32], Lo=product[31:0]. For signed ops the product is negated when operand signs differ.
- Divide: Lo=quotient, Hi=remainder.
  - Signed: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Divide by zero: Lo=32'hFFFFFFFF, Hi=dividend (raw DataOne).
  - 0x80000000 / 0xFFFFFFFF signed: Lo=0x80000000, Hi=0.
- MTHI/MTLO (R-type, IDLE, !Flush_Ex): Hi or Lo <= DataOne_Ex at the clock edge. No stall.
- MFHI/MFLO never stall. The unit blocks EX while busy, so a following MFHI/MFLO always reads completed values.
- Flush_Ex in RUN: return to IDLE next cycle; Hi/Lo unchanged; Stall_Ex drops that cycle. Flush_Ex in IDLE suppresses start and MTHI/MTLO.
- Stall_Ex/Flush_Ex simultaneous: Flush_Ex wins.

Optional Feature:
MULDIV_EARLY_TERM_EN:
- Defined: multiply (not divide) leaves RUN as soon as the remaining multiplier bits are all zero, with a minimum of 1 RUN cycle. The partial product is shifted into its final position before Hi/Lo are written, so results are identical to the full-length operation; only latency shrinks.
- Undefined: every operation takes exactly ITER RUN cycles.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; Stall_Ex high 33 cycles; Done pulses once.
- MULT -7*3 (0xFFFFFFF9, 3) -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; then MFLO -> Result_Ex=0xFFFFFFEB with no stall.
- DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 100/0 -> Lo=0xFFFFFFFF, Hi=100.
- MTHI 0x1234 then MFHI -> Result_Ex=0x1234; DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start MULT; assert Flush_Ex at RUN cycle 10 -> IDLE next cycle, Hi/Lo keep prior values, no Done; repeat with reset at cycle 10 -> Hi=Lo=0, Stall_Ex=0.
- With MULDIV_EARLY_TERM_EN: MULTU 5*3 -> Hi=0, Lo=15 after <=3 RUN cycles; without the macro -> same result after exactly 32 RUN cycles.
